// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM state
// encoding and grant identifiers.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_I_REQ  = 3'd1,
    ST_I_WAIT = 3'd2,
    ST_D_REQ  = 3'd3,
    ST_D_WAIT = 3'd4
  } arbState_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Free-running enable counter with synchronous clear; wraps modulo 2^W.
// Used by mem_arbiter only when MEM_ARB_PERF_CNT_EN is defined.
module mem_arb_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)     count <= '0;
    else if (en) count <= count + W'(1);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of fetch and data accesses onto one memory port, with
// the pipeline Stall. Define MEM_ARB_PERF_CNT_EN to add stall/request counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                IReq,
  input  logic [ADDR_W-1:0]   IAddr,
  output logic [DATA_W-1:0]   IRdata,
  output logic                IValid,
  input  logic                DReq,
  input  logic                DWe,
  input  logic [ADDR_W-1:0]   DAddr,
  input  logic [DATA_W-1:0]   DWdata,
  input  logic [DATA_W/8-1:0] DWmask,
  output logic [DATA_W-1:0]   DRdata,
  output logic                DValid,
  output logic                MemReqValid,
  input  logic                MemReqRdy,
  output logic                MemReqWe,
  output logic [ADDR_W-1:0]   MemReqAddr,
  output logic [DATA_W-1:0]   MemReqData,
  output logic [DATA_W/8-1:0] MemReqMask,
  input  logic                MemRespValid,
  input  logic [DATA_W-1:0]   MemRespData,
  output logic                Stall
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] StallCycles,
  output logic [PERF_CNT_W-1:0] ReqCount
`endif
);

  arbState_t state, stateNext;
  grant_t    lastGrant, lastGrantNext;

  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lastGrant <= GRANT_I;
    end else begin
      state     <= stateNext;
      lastGrant <= lastGrantNext;
    end
  end

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    stateNext     = state;
    lastGrantNext = lastGrant;
    IValid        = 1'b0;
    IRdata        = '0;
    DValid        = 1'b0;
    DRdata        = '0;
    MemReqValid   = 1'b0;
    MemReqWe      = 1'b0;
    MemReqAddr    = '0;
    MemReqData    = '0;
    MemReqMask    = '0;

    unique case (state)
      ST_IDLE: begin
        // Under contention the side that lost last time wins.
        if (DReq && (!IReq || lastGrant == GRANT_I)) begin
          stateNext     = ST_D_REQ;
          lastGrantNext = GRANT_D;
        end else if (IReq) begin
          stateNext     = ST_I_REQ;
          lastGrantNext = GRANT_I;
        end
      end
      ST_I_REQ: begin
        MemReqValid = 1'b1;
        MemReqAddr  = IAddr;
        if (MemReqRdy) stateNext = ST_I_WAIT;
      end
      ST_I_WAIT: begin
        if (MemRespValid) begin
          IValid    = 1'b1;
          IRdata    = MemRespData;
          stateNext = ST_IDLE;
        end
      end
      ST_D_REQ: begin
        MemReqValid = 1'b1;
        MemReqWe    = DWe;
        MemReqAddr  = DAddr;
        MemReqData  = DWdata;
        MemReqMask  = DWmask;
        // Stores complete on acceptance; no response follows.
        if (MemReqRdy) begin
          DValid    = DWe;
          stateNext = DWe ? ST_IDLE : ST_D_WAIT;
        end
      end
      ST_D_WAIT: begin
        if (MemRespValid) begin
          DValid    = 1'b1;
          DRdata    = MemRespData;
          stateNext = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  assign Stall = (IReq & ~IValid) | (DReq & ~DValid);

`ifdef MEM_ARB_PERF_CNT_EN
  mem_arb_perf_cnt #(.W(PERF_CNT_W)) uStallCnt (
    .clk   (clk),
    .rst   (rst),
    .en    (Stall),
    .count (StallCycles)
  );

  mem_arb_perf_cnt #(.W(PERF_CNT_W)) uReqCnt (
    .clk   (clk),
    .rst   (rst),
    .en    (MemReqValid & MemReqRdy),
    .count (ReqCount)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          IReq, IValid, DReq, DWe, DValid;
  logic [AW-1:0] IAddr, DAddr, MemReqAddr;
  logic [DW-1:0] IRdata, DRdata, DWdata, MemReqData, MemRespData;
  logic [MW-1:0] DWmask, MemReqMask;
  logic          MemReqValid, MemReqRdy, MemReqWe, MemRespValid, Stall;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]   StallCycles, ReqCount;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .IReq         (IReq),
    .IAddr        (IAddr),
    .IRdata       (IRdata),
    .IValid       (IValid),
    .DReq         (DReq),
    .DWe          (DWe),
    .DAddr        (DAddr),
    .DWdata       (DWdata),
    .DWmask       (DWmask),
    .DRdata       (DRdata),
    .DValid       (DValid),
    .MemReqValid  (MemReqValid),
    .MemReqRdy    (MemReqRdy),
    .MemReqWe     (MemReqWe),
    .MemReqAddr   (MemReqAddr),
    .MemReqData   (MemReqData),
    .MemReqMask   (MemReqMask),
    .MemRespValid (MemRespValid),
    .MemRespData  (MemRespData),
    .Stall        (Stall)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .StallCycles  (StallCycles),
    .ReqCount     (ReqCount)
`endif
  );

  int errCount   = 0;
  int checkCount = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the one transaction in flight, seen as "who owns the
  // port" and "has the memory taken the request yet".
  bit          xActive   = 1'b0;
  bit          xIsD      = 1'b0;
  bit          xAccepted = 1'b0;
  bit          lastWasD  = 1'b0;
  bit          doneI, doneD;
  logic [31:0] stallTally = '0;
  logic [31:0] reqTally   = '0;

  // Compares all outputs for the current cycle, then advances one clock.
  task automatic step();
    bit eReq, eI, eD, eStall, sRst, sIReq, sDReq, sRdy;
    #1;
    eReq   = xActive && !xAccepted;
    eI     = xActive && !xIsD && xAccepted && MemRespValid;
    eD     = xActive && xIsD && ((xAccepted && MemRespValid) || (!xAccepted && DWe && MemReqRdy));
    eStall = (IReq && !eI) || (DReq && !eD);

    check("MemReqValid", MemReqValid, eReq);
    check("MemReqWe",   MemReqWe,   eReq && xIsD && DWe);
    check("MemReqAddr", MemReqAddr, !eReq ? '0 : (xIsD ? DAddr : IAddr));
    check("MemReqData", MemReqData, (eReq && xIsD) ? DWdata : '0);
    check("MemReqMask", MemReqMask, (eReq && xIsD) ? DWmask : '0);
    check("IValid", IValid, eI);
    check("DValid", DValid, eD);
    if (eI) check("IRdata", IRdata, MemRespData);
    if (eD && xAccepted) check("DRdata", DRdata, MemRespData);
    check("Stall", Stall, eStall);
`ifdef MEM_ARB_PERF_CNT_EN
    check("StallCycles", StallCycles, stallTally);
    check("ReqCount", ReqCount, reqTally);
`endif
    doneI = eI;
    doneD = eD;
    sRst  = rst;
    sIReq = IReq;
    sDReq = DReq;
    sRdy  = MemReqRdy;
    @(posedge clk);
    if (sRst) begin
      xActive    = 1'b0;
      lastWasD   = 1'b0;
      stallTally = '0;
      reqTally   = '0;
    end else begin
      stallTally += 32'(eStall);
      reqTally   += 32'(eReq && sRdy);
      if (!xActive) begin
        if (sIReq || sDReq) begin
          xActive   = 1'b1;
          xAccepted = 1'b0;
          xIsD      = (sIReq && sDReq) ? !lastWasD : sDReq;
          lastWasD  = xIsD;
        end
      end else if (eI || eD) begin
        xActive = 1'b0;
      end else if (eReq && sRdy) begin
        xAccepted = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    IReq = 0; IAddr = '0; DReq = 0; DWe = 0; DAddr = '0; DWdata = '0; DWmask = '0;
    MemReqRdy = 0; MemRespValid = 0; MemRespData = '0;
  endtask

  logic [AW-1:0] grants[$];

  initial begin
    quiet();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step();
    rst = 1'b0;
    #1;
    check("reset_MemReqValid", MemReqValid, 1'b0);
    check("reset_Stall", Stall, 1'b0);
    check("reset_IValid", IValid, 1'b0);
    check("reset_DValid", DValid, 1'b0);
    step();

    // Fetch only: accepted in cycle 1, answered in cycle 3.
    IReq = 1; IAddr = 32'h100;
    #1; check("fetch_c0_Stall", Stall, 1'b1);
    step();
    MemReqRdy = 1;
    #1; check("fetch_c1_Addr", MemReqAddr, 32'h100);
    check("fetch_c1_We", MemReqWe, 1'b0);
    check("fetch_c1_Stall", Stall, 1'b1);
    step();
    MemReqRdy = 0;
    #1; check("fetch_c2_Stall", Stall, 1'b1);
    step();
    MemRespValid = 1; MemRespData = 32'hDEADBEEF;
    #1; check("fetch_c3_IValid", IValid, 1'b1);
    check("fetch_c3_IRdata", IRdata, 32'hDEADBEEF);
    check("fetch_c3_Stall", Stall, 1'b0);
    step();
    quiet();
    step();

    // Store only, memory always ready.
    DReq = 1; DWe = 1; DAddr = 32'h2000; DWdata = 32'h12345678; DWmask = 4'hF; MemReqRdy = 1;
    step();
    #1; check("store_ReqValid", MemReqValid, 1'b1);
    check("store_DValid", DValid, 1'b1);
    check("store_Mask", MemReqMask, 4'hF);
    check("store_Stall", Stall, 1'b0);
    step();
    DReq = 0; MemRespValid = 1;
    #1; check("store_no_wait", DValid, 1'b0);
    step();
    quiet();
    rst = 1; step(); rst = 0;

    // Contention after reset: D, then I, then D again.
    IReq = 1; IAddr = 32'h400; DReq = 1; DWe = 0; DAddr = 32'h300;
    MemReqRdy = 1; MemRespValid = 1; MemRespData = 32'hCAFE0001;
    for (int c = 0, nD = 0; c < 10; c++) begin
      #1;
      if (MemReqValid && MemReqRdy) grants.push_back(MemReqAddr);
      step();
      if (doneD) begin
        if (nD == 0) DAddr = 32'h500; else DReq = 0;
        nD++;
      end
      if (doneI) IReq = 0;
    end
    check("rr_count", grants.size(), 3);
    if (grants.size() == 3) begin
      check("rr_first_D", grants[0], 32'h300);
      check("rr_then_I", grants[1], 32'h400);
      check("rr_then_D", grants[2], 32'h500);
    end
    quiet();
    step();

    // Backpressure: request held stable while memory not ready.
    IReq = 1; IAddr = 32'h600;
    step();
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_Valid", MemReqValid, 1'b1);
      check("bp_Addr", MemReqAddr, 32'h600);
      check("bp_We", MemReqWe, 1'b0);
      check("bp_Stall", Stall, 1'b1);
      step();
    end
    MemReqRdy = 1; step();
    MemReqRdy = 0; MemRespValid = 1; step();
    quiet(); step();

    // Reset while waiting on a load; the late response is dropped.
    DReq = 1; DWe = 0; DAddr = 32'h700; MemReqRdy = 1;
    step();
    step();
    MemReqRdy = 0; rst = 1;
    step();
    rst = 0; DReq = 0; MemRespValid = 1; MemRespData = 32'h55AA55AA;
    #1;
    check("rstload_DValid", DValid, 1'b0);
    check("rstload_ReqValid", MemReqValid, 1'b0);
    check("rstload_Stall", Stall, 1'b0);
    check("rstload_IValid", IValid, 1'b0);
    step();
    quiet(); step();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (doneI) begin
        IReq = $urandom_range(0, 1); IAddr = $urandom;
      end else if (!IReq && $urandom_range(0, 3) == 0) begin
        IReq = 1; IAddr = $urandom;
      end
      if (doneD || (!DReq && $urandom_range(0, 3) == 0)) begin
        DReq = doneD ? 1'($urandom_range(0, 1)) : 1'b1;
        DWe = $urandom_range(0, 1); DAddr = $urandom; DWdata = $urandom;
        DWmask = MW'($urandom);
      end
      MemReqRdy    = ($urandom_range(0, 2) != 0);
      MemRespValid = $urandom_range(0, 1);
      MemRespData  = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
